// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: shared immediate formats, instruction field positions and skid states
package imm_pkg;
  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_D  = 3'd1,
    FMT_B  = 3'd2,
    FMT_CB = 3'd3,
    FMT_IW = 3'd4
  } imm_fmt_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
  localparam int I_LSB  = 10;
  localparam int I_MSB  = 21;
  localparam int D_LSB  = 12;
  localparam int D_MSB  = 20;
  localparam int B_MSB  = 25;
  localparam int CB_LSB = 5;
  localparam int CB_MSB = 23;
  localparam int IW_LSB = 5;
  localparam int IW_MSB = 20;
  localparam int HW_LSB = 21;
  localparam int HW_MSB = 22;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out valid-ready bus
interface imm_gen_pipe_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [2:0]        in_fmt;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  modport master (
    output in_valid, in_instr, in_fmt, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );
  modport slave (
    input  in_valid, in_instr, in_fmt, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: combinational LEGv8 immediate extraction, computed at 64 bits
module imm_extract
  import imm_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 2
) (
  input  logic [31:0]       instr_i,
  input  logic [2:0]        fmt_i,
  output logic [DATA_W-1:0] imm_o,
  output logic              err_o
);
  logic [63:0] res;
  logic [1:0]  hw;
  logic        unused_bits;
  always_comb begin
    hw    = instr_i[HW_MSB:HW_LSB];
    res   = fmt_i == FMT_I  ? 64'(instr_i[I_MSB:I_LSB]) :
            fmt_i == FMT_D  ? 64'($signed(instr_i[D_MSB:D_LSB])) :
            fmt_i == FMT_B  ? 64'($signed(instr_i[B_MSB:0])) << BR_SHIFT :
            fmt_i == FMT_CB ? 64'($signed(instr_i[CB_MSB:CB_LSB])) << BR_SHIFT :
            fmt_i == FMT_IW ? 64'(instr_i[IW_MSB:IW_LSB]) << {hw, 4'b0000} : 64'd0;
    err_o = fmt_i > FMT_IW || (DATA_W == 32 && fmt_i == FMT_IW && hw[1]);
    imm_o = err_o ? '0 : res[DATA_W-1:0];
  end
  assign unused_bits = ^{instr_i[31:26], res >> DATA_W};
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator behind a 2-entry skid buffer (main + skid)
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 6,
  parameter int BR_SHIFT = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush,
  imm_gen_pipe_if.slave bus
);
  skid_state_t       state_q, state_d;
  logic              in_ready_q, fire_in, fire_out, load_main, load_skid, pop_skid;
  logic [DATA_W-1:0] ext_imm, main_imm_q, skid_imm_q;
  logic              ext_err, main_err_q, skid_err_q;
  logic [TAG_W-1:0]  main_tag_q, skid_tag_q;
  imm_extract #(.DATA_W(DATA_W), .BR_SHIFT(BR_SHIFT)) u_extract (
    .instr_i(bus.in_instr),
    .fmt_i  (bus.in_fmt),
    .imm_o  (ext_imm),
    .err_o  (ext_err)
  );
  assign fire_in  = bus.in_valid & in_ready_q;
  assign fire_out = bus.out_valid & bus.out_ready;
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state_q)
      EMPTY: begin
        state_d   = fire_in ? ONE : EMPTY;
        load_main = fire_in;
      end
      ONE: begin
        state_d   = fire_in && !fire_out ? TWO : !fire_in && fire_out ? EMPTY : ONE;
        load_main = fire_in & fire_out;
        load_skid = fire_in & ~fire_out;
      end
      TWO: begin
        state_d  = fire_out ? ONE : TWO;
        pop_skid = fire_out;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      pop_skid  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d != TWO;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_err_q <= 1'b0;
    end else if (load_main) begin
      main_imm_q <= ext_imm;
      main_tag_q <= bus.in_tag;
      main_err_q <= ext_err;
    end else if (pop_skid) begin
      main_imm_q <= skid_imm_q;
      main_tag_q <= skid_tag_q;
      main_err_q <= skid_err_q;
    end
  end
  // Skid contents are only meaningful in TWO, so they carry no reset
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm_q <= ext_imm;
      skid_tag_q <= bus.in_tag;
      skid_err_q <= ext_err;
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = state_q != EMPTY;
  assign bus.out_imm   = main_imm_q;
  assign bus.out_tag   = main_tag_q;
  assign bus.out_err   = main_err_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table-driven format checks on 64/32-bit instances plus handshake sequences
module tb_imm_gen_pipe;
  import imm_pkg::*;
  typedef struct packed {
    logic [2:0]  fmt;
    logic [31:0] instr;
    logic [63:0] imm64;
    logic        err64;
    logic [31:0] imm32;
    logic        err32;
  } vec_t;
  logic clk, rst_n, flush;
  int checks, errors;
  vec_t vecs [16];
  imm_gen_pipe_if #(.DATA_W(64), .TAG_W(6)) b64 ();
  imm_gen_pipe_if #(.DATA_W(32), .TAG_W(6)) b32 ();
  imm_gen_pipe #(.DATA_W(64), .TAG_W(6), .BR_SHIFT(2)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));
  imm_gen_pipe #(.DATA_W(32), .TAG_W(6), .BR_SHIFT(2)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input logic [5:0] tag);
    b64.in_valid = v;
    b64.in_fmt   = FMT_I;
    b64.in_instr = (32'h100 + 32'(tag)) << 10;
    b64.in_tag   = tag;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{3'd0, 32'h003FFC00, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0};
    vecs[1]  = '{3'd0, 32'hFFFFFFFF, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0};
    vecs[2]  = '{3'd1, 32'h00100000, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 32'hFFFF_FF00, 1'b0};
    vecs[3]  = '{3'd1, 32'h000FF000, 64'h0000_0000_0000_00FF, 1'b0, 32'h0000_00FF, 1'b0};
    vecs[4]  = '{3'd2, 32'h03FFFFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vecs[5]  = '{3'd2, 32'h01000000, 64'h0000_0000_0400_0000, 1'b0, 32'h0400_0000, 1'b0};
    vecs[6]  = '{3'd2, 32'h02000000, 64'hFFFF_FFFF_F800_0000, 1'b0, 32'hF800_0000, 1'b0};
    vecs[7]  = '{3'd3, 32'h00000020, 64'h0000_0000_0000_0004, 1'b0, 32'h0000_0004, 1'b0};
    vecs[8]  = '{3'd3, 32'h00800000, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 32'hFFF0_0000, 1'b0};
    vecs[9]  = '{3'd4, 32'h0017DDE0, 64'h0000_0000_0000_BEEF, 1'b0, 32'h0000_BEEF, 1'b0};
    vecs[10] = '{3'd4, 32'h0037DDE0, 64'h0000_0000_BEEF_0000, 1'b0, 32'hBEEF_0000, 1'b0};
    vecs[11] = '{3'd4, 32'h0057DDE0, 64'h0000_BEEF_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[12] = '{3'd4, 32'h0077DDE0, 64'hBEEF_0000_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[13] = '{3'd6, 32'h0077DDE0, 64'h0000_0000_0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[14] = '{3'd5, 32'h003FFC00, 64'h0000_0000_0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[15] = '{3'd7, 32'hFFFFFFFF, 64'h0000_0000_0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    rst_n = 1'b0;
    flush = 1'b0;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_fmt = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_fmt = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(b64.out_valid), 64'd0);
    chk("rst_in_ready", 64'(b64.in_ready), 64'd1);
    chk("rst_out_imm", b64.out_imm, 64'd0);
    chk("rst_out_tag", 64'(b64.out_tag), 64'd0);
    chk("rst_out_err", 64'(b64.out_err), 64'd0);
    chk("rst32_in_ready", 64'(b32.in_ready), 64'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b64.in_valid = 1'b1; b64.in_fmt = vecs[i].fmt; b64.in_instr = vecs[i].instr; b64.in_tag = 6'(i);
      b32.in_valid = 1'b1; b32.in_fmt = vecs[i].fmt; b32.in_instr = vecs[i].instr; b32.in_tag = 6'(i);
      step();
      chk($sformatf("v%0d_valid", i), 64'(b64.out_valid), 64'd1);
      chk($sformatf("v%0d_imm64", i), b64.out_imm, vecs[i].imm64);
      chk($sformatf("v%0d_err64", i), 64'(b64.out_err), 64'(vecs[i].err64));
      chk($sformatf("v%0d_tag", i), 64'(b64.out_tag), 64'(i));
      chk($sformatf("v%0d_imm32", i), 64'(b32.out_imm), 64'(vecs[i].imm32));
      chk($sformatf("v%0d_err32", i), 64'(b32.out_err), 64'(vecs[i].err32));
    end
    b64.in_valid = 1'b0;
    b32.in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(b64.out_valid), 64'd0);
    b64.out_ready = 1'b0;
    drv(1'b1, 6'd0);
    step();
    chk("bp0_valid", 64'(b64.out_valid), 64'd1);
    chk("bp0_in_ready", 64'(b64.in_ready), 64'd1);
    chk("bp0_tag", 64'(b64.out_tag), 64'd0);
    drv(1'b1, 6'd1);
    step();
    chk("bp1_in_ready", 64'(b64.in_ready), 64'd0);
    chk("bp1_tag", 64'(b64.out_tag), 64'd0);
    drv(1'b1, 6'd2);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d_valid", k), 64'(b64.out_valid), 64'd1);
      chk($sformatf("stall%0d_tag", k), 64'(b64.out_tag), 64'd0);
      chk($sformatf("stall%0d_imm", k), b64.out_imm, 64'h100);
      chk($sformatf("stall%0d_err", k), 64'(b64.out_err), 64'd0);
      chk($sformatf("stall%0d_in_ready", k), 64'(b64.in_ready), 64'd0);
    end
    b64.out_ready = 1'b1;
    step();
    chk("rel1_valid", 64'(b64.out_valid), 64'd1);
    chk("rel1_tag", 64'(b64.out_tag), 64'd1);
    chk("rel1_imm", b64.out_imm, 64'h101);
    chk("rel1_in_ready", 64'(b64.in_ready), 64'd1);
    step();
    chk("rel2_valid", 64'(b64.out_valid), 64'd1);
    chk("rel2_tag", 64'(b64.out_tag), 64'd2);
    chk("rel2_imm", b64.out_imm, 64'h102);
    drv(1'b0, 6'd0);
    step();
    chk("rel_empty", 64'(b64.out_valid), 64'd0);
    b64.out_ready = 1'b0;
    drv(1'b1, 6'd5);
    step();
    drv(1'b1, 6'd6);
    step();
    chk("fl2_pre_in_ready", 64'(b64.in_ready), 64'd0);
    flush = 1'b1;
    drv(1'b1, 6'd7);
    step();
    flush = 1'b0;
    chk("fl2_valid", 64'(b64.out_valid), 64'd0);
    chk("fl2_in_ready", 64'(b64.in_ready), 64'd1);
    drv(1'b0, 6'd0);
    b64.out_ready = 1'b1;
    step();
    chk("fl2_after_valid", 64'(b64.out_valid), 64'd0);
    b64.out_ready = 1'b0;
    drv(1'b1, 6'd8);
    step();
    chk("fl1_pre_valid", 64'(b64.out_valid), 64'd1);
    flush = 1'b1;
    drv(1'b1, 6'd9);
    step();
    flush = 1'b0;
    drv(1'b0, 6'd0);
    chk("fl1_valid", 64'(b64.out_valid), 64'd0);
    chk("fl1_in_ready", 64'(b64.in_ready), 64'd1);
    step();
    chk("fl1_after_valid", 64'(b64.out_valid), 64'd0);
    drv(1'b1, 6'd3);
    step();
    drv(1'b0, 6'd0);
    chk("ar_pre_valid", 64'(b64.out_valid), 64'd1);
    chk("ar_pre_tag", 64'(b64.out_tag), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(b64.out_valid), 64'd0);
    chk("ar_in_ready", 64'(b64.in_ready), 64'd1);
    chk("ar_tag", 64'(b64.out_tag), 64'd0);
    chk("ar_imm", b64.out_imm, 64'd0);
    #1 rst_n = 1'b1;
    b64.out_ready = 1'b1;
    drv(1'b1, 6'd4);
    step();
    chk("ar_resume_valid", 64'(b64.out_valid), 64'd1);
    chk("ar_resume_tag", 64'(b64.out_tag), 64'd4);
    chk("ar_resume_imm", b64.out_imm, 64'h104);
    drv(1'b0, 6'd0);
    step();
    chk("ar_resume_empty", 64'(b64.out_valid), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
